ledpanel_bcm: RTL and testbench

Parametrised HUB75 RGB LED matrix driver and the successor to the single-bit `ledpanel` driver. It sits between the embedded system's pixel-write interface (`x_address`, `y_address`, `color`, `new_data`, `update_panel`) and the panel connector pins. It adds the following over that driver:
- configurable panel size;
- multi-bit colour per channel using binary-coded modulation (BCM);
- a double-buffered framebuffer with tear-free swap at frame boundaries.

Software writes pixels into the back buffer while the front buffer is scanned continuously.

---
 rtl/ledpanel_bcm_pkg.sv | 28 ++
 rtl/ledpanel_bcm_if.sv | 23 ++
 rtl/ledpanel_bcm_framebuffer_ram.sv | 23 ++
 rtl/ledpanel_bcm.sv | 239 +++++++++++++++++++++++
 tb/tb_ledpanel_bcm.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ledpanel_bcm_pkg.sv
// Shared types and helpers for the BCM LED panel driver.
package ledpanel_pkg;

  // Scan FSM states. Each state is one phase of a (row, plane) slot.
  typedef enum logic [1:0] {
    SHIFT   = 2'd0,
    BLANK   = 2'd1,
    LATCH   = 2'd2,
    DISPLAY = 2'd3
  } scan_state_e;

  // Bit position of each channel inside a packed {R,G,B} pixel, in units of channel width.
  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  // Width of the shared slot counter. It must hold the longest DISPLAY
  // period (BASE_TICKS << (COLOR_BITS-1)) as well as the BLANK and LATCH lengths.
  function automatic int tick_cnt_width(input int base_ticks, input int color_bits,
                                        input int blank_cycles, input int clk_div);
    int longest;
    longest = base_ticks << (color_bits - 1);
    if (blank_cycles > longest) longest = blank_cycles;
    if (clk_div > longest) longest = clk_div;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/ledpanel_bcm_if.sv
// Pixel-write and swap-request bus between the host system and the panel driver.
interface ledpanel_bcm_if #(
  parameter int PANEL_W    = 32,
  parameter int PANEL_H    = 16,
  parameter int COLOR_BITS = 4
);
  logic                          new_data;
  logic [$clog2(PANEL_W)-1:0]    x_address;
  logic [$clog2(PANEL_H)-1:0]    y_address;
  logic [3*COLOR_BITS-1:0]       color;
  logic                          update_panel;
  logic                          swap_done;

  modport master (
    output new_data, x_address, y_address, color, update_panel,
    input  swap_done
  );

  modport slave (
    input  new_data, x_address, y_address, color, update_panel,
    output swap_done
  );
endinterface

// File: rtl/ledpanel_bcm_framebuffer_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module framebuffer_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 12,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write when strobed; read every cycle with one cycle of latency.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/ledpanel_bcm.sv
// HUB75 panel driver with binary-coded modulation and a double-buffered framebuffer.
// The front buffer is scanned continuously; the host writes the back buffer and
// requests a swap, which takes effect only at a frame boundary.
module ledpanel_bcm
  import ledpanel_pkg::*;
#(
  parameter int PANEL_W      = 32,
  parameter int PANEL_H      = 16,
  parameter int COLOR_BITS   = 4,
  parameter int CLK_DIV      = 2,
  parameter int BASE_TICKS   = 8,
  parameter int BLANK_CYCLES = 2,
  localparam int SCAN        = PANEL_H / 2,
  localparam int ROW_BITS    = $clog2(SCAN)
) (
  input  logic                clk,
  input  logic                sysreset,
  ledpanel_bcm_if.slave       bus,
  output logic [2:0]          led_rgb1,
  output logic [2:0]          led_rgb2,
  output logic [ROW_BITS-1:0] led_abc,
  output logic                led_clk,
  output logic                led_latch,
  output logic                led_oe
);

  localparam int X_BITS = $clog2(PANEL_W);
  localparam int Y_BITS = ROW_BITS + 1;
  localparam int PIX_W  = 3 * COLOR_BITS;
  localparam int AW     = 1 + ROW_BITS + X_BITS;
  localparam int DEPTH  = 2 * SCAN * PANEL_W;
  localparam int PH_W   = $clog2(2 * CLK_DIV);
  localparam int PL_W   = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam int CNT_W  = tick_cnt_width(BASE_TICKS, COLOR_BITS, BLANK_CYCLES, CLK_DIV);

  localparam logic [PH_W-1:0]     PH_LAST    = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]     PH_CLK_HI  = PH_W'(CLK_DIV);
  localparam logic [X_BITS-1:0]   COL_LAST   = X_BITS'(PANEL_W - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST   = ROW_BITS'(SCAN - 1);
  localparam logic [PL_W-1:0]     PLANE_LAST = PL_W'(COLOR_BITS - 1);
  localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]    LATCH_LAST = CNT_W'(CLK_DIV - 1);

  // Scan state
  scan_state_e         state_q, state_d;
  logic [X_BITS-1:0]   col_q, col_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [PL_W-1:0]     plane_q, plane_d;

  // Buffer management
  logic front_q, front_d;
  logic swap_pend_q, swap_pend_d;
  logic frame_valid_q, frame_valid_d;
  logic swap_done_q, swap_done_d;

  // Registered panel outputs
  logic [2:0]          rgb1_q, rgb1_d;
  logic [2:0]          rgb2_q, rgb2_d;
  logic [ROW_BITS-1:0] abc_q, abc_d;
  logic                lclk_q, lclk_d;
  logic                latch_q, latch_d;
  logic                oe_q, oe_d;

  logic [CNT_W-1:0]    disp_last;
  logic [AW-1:0]       waddr, raddr;
  logic                we_top, we_bot;
  logic [PIX_W-1:0]    rdata_top, rdata_bot;

  // Pick bit 'plane' of each channel from a packed {R,G,B} pixel.
  function automatic logic [2:0] plane_bits(input logic [PIX_W-1:0] pix, input logic [PL_W-1:0] plane);
    return {pix[CH_R * COLOR_BITS + int'(plane)],
            pix[CH_G * COLOR_BITS + int'(plane)],
            pix[CH_B * COLOR_BITS + int'(plane)]};
  endfunction

  // Host writes always target the back buffer of the half chosen by the row MSB;
  // the scanner always reads the front buffer, so the two ports never collide.
  assign waddr  = {~front_q, bus.y_address[ROW_BITS-1:0], bus.x_address};
  assign we_top = bus.new_data & ~bus.y_address[Y_BITS-1];
  assign we_bot = bus.new_data &  bus.y_address[Y_BITS-1];
  assign raddr  = {front_q, row_q, col_q};

  framebuffer_ram #(.DEPTH(DEPTH), .WIDTH(PIX_W)) u_ram_top (
    .clk     (clk),
    .we_i    (we_top),
    .waddr_i (waddr),
    .wdata_i (bus.color),
    .raddr_i (raddr),
    .rdata_o (rdata_top)
  );

  framebuffer_ram #(.DEPTH(DEPTH), .WIDTH(PIX_W)) u_ram_bot (
    .clk     (clk),
    .we_i    (we_bot),
    .waddr_i (waddr),
    .wdata_i (bus.color),
    .raddr_i (raddr),
    .rdata_o (rdata_bot)
  );

  assign disp_last = (CNT_W'(BASE_TICKS) << plane_q) - CNT_W'(1);

  // Next-state and next-output logic; outputs are derived from the next state so
  // the registered pins line up with the state they describe.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    row_d         = row_q;
    plane_d       = plane_q;
    front_d       = front_q;
    swap_pend_d   = swap_pend_q | bus.update_panel;
    frame_valid_d = frame_valid_q;
    swap_done_d   = 1'b0;

    unique case (state_q)
      SHIFT: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            cnt_d   = '0;
            state_d = BLANK;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = LATCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          cnt_d   = '0;
          state_d = DISPLAY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DISPLAY: begin
        if (cnt_q == disp_last) begin
          cnt_d   = '0;
          state_d = SHIFT;
          if (plane_q == PLANE_LAST) begin
            plane_d = '0;
            if (row_q == ROW_LAST) begin
              // Frame boundary: a pending (or same-cycle) request swaps here.
              row_d = '0;
              if (swap_pend_d) begin
                front_d       = ~front_q;
                swap_pend_d   = 1'b0;
                frame_valid_d = 1'b1;
                swap_done_d   = 1'b1;
              end
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            plane_d = plane_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SHIFT;
    endcase

    lclk_d  = (state_d == SHIFT) && (phase_d >= PH_CLK_HI);
    latch_d = (state_d == LATCH);
    oe_d    = !((state_d == DISPLAY) && frame_valid_d);
    abc_d   = ((state_d == BLANK) && (state_q != BLANK)) ? row_q : abc_q;

    // RAM data for the current column arrives in phase 1; present it from phase 2.
    rgb1_d = rgb1_q;
    rgb2_d = rgb2_q;
    if ((state_q == SHIFT) && (phase_q == PH_W'(1))) begin
      rgb1_d = plane_bits(rdata_top, plane_q);
      rgb2_d = plane_bits(rdata_bot, plane_q);
    end
  end

  // Scan FSM, swap bookkeeping and registered panel outputs.
  always_ff @(posedge clk or negedge sysreset) begin
    if (!sysreset) begin
      state_q       <= SHIFT;
      col_q         <= '0;
      phase_q       <= '0;
      cnt_q         <= '0;
      row_q         <= '0;
      plane_q       <= '0;
      front_q       <= 1'b0;
      swap_pend_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      swap_done_q   <= 1'b0;
      rgb1_q        <= '0;
      rgb2_q        <= '0;
      abc_q         <= '0;
      lclk_q        <= 1'b0;
      latch_q       <= 1'b0;
      oe_q          <= 1'b1;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      plane_q       <= plane_d;
      front_q       <= front_d;
      swap_pend_q   <= swap_pend_d;
      frame_valid_q <= frame_valid_d;
      swap_done_q   <= swap_done_d;
      rgb1_q        <= rgb1_d;
      rgb2_q        <= rgb2_d;
      abc_q         <= abc_d;
      lclk_q        <= lclk_d;
      latch_q       <= latch_d;
      oe_q          <= oe_d;
    end
  end

  assign bus.swap_done = swap_done_q;
  assign led_rgb1      = rgb1_q;
  assign led_rgb2      = rgb2_q;
  assign led_abc       = abc_q;
  assign led_clk       = lclk_q;
  assign led_latch     = latch_q;
  assign led_oe        = oe_q;

endmodule

// File: tb/tb_ledpanel_bcm.sv
// Directed bench for ledpanel_bcm on an 8x16 panel with 4 colour planes.
// Slot length = 4*8 + 2 + 2 + (8<<plane) = 44/52/68/100; row = 264; frame = 2112.
module tb_ledpanel_bcm;
  import ledpanel_pkg::*;

  localparam int W     = 8;
  localparam int H     = 16;
  localparam int CB    = 4;
  localparam int CD    = 2;
  localparam int BT    = 8;
  localparam int BK    = 2;
  localparam int SCAN  = H / 2;
  localparam int FRAME = 2112;

  logic       clk = 1'b0;
  logic       sysreset = 1'b1;
  logic [2:0] led_rgb1, led_rgb2, led_abc;
  logic       led_clk, led_latch, led_oe;

  ledpanel_bcm_if #(.PANEL_W(W), .PANEL_H(H), .COLOR_BITS(CB)) bus ();

  ledpanel_bcm #(
    .PANEL_W(W), .PANEL_H(H), .COLOR_BITS(CB),
    .CLK_DIV(CD), .BASE_TICKS(BT), .BLANK_CYCLES(BK)
  ) dut (
    .clk       (clk),
    .sysreset  (sysreset),
    .bus       (bus),
    .led_rgb1  (led_rgb1),
    .led_rgb2  (led_rgb2),
    .led_abc   (led_abc),
    .led_clk   (led_clk),
    .led_latch (led_latch),
    .led_oe    (led_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Running observations, updated once per cycle by sample().
  int rise_cnt = 0, latch_cnt = 0, swap_cnt = 0, oe_low_cnt = 0, viol_cnt = 0;
  logic prev_clk = 1'b0, prev_latch = 1'b0;
  logic [2:0] prev_abc = 3'd0;

  // Per-slot capture results.
  logic [23:0] cap_r1, cap_r2;
  logic [2:0]  cap_abc;
  int cap_rises, cap_oe, cap_loff, cap_llen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
    end
  endtask

  task automatic sample();
    if (led_clk === 1'b1 && prev_clk === 1'b0) rise_cnt++;
    if (led_latch === 1'b1 && prev_latch === 1'b0) latch_cnt++;
    if (led_oe === 1'b0) oe_low_cnt++;
    if (bus.swap_done === 1'b1) swap_cnt++;
    if (led_latch === 1'b1 && led_oe === 1'b0) viol_cnt++;
    if (led_oe === 1'b0 && led_abc !== prev_abc) viol_cnt++;
    prev_clk   = led_clk;
    prev_latch = led_latch;
    prev_abc   = led_abc;
  endtask

  task automatic step();
    sample();
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_px(input int x, input int y, input logic [11:0] c);
    bus.new_data  = 1'b1;
    bus.x_address = 3'(x);
    bus.y_address = 4'(y);
    bus.color     = c;
    step();
    bus.new_data  = 1'b0;
  endtask

  task automatic clear_back();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        write_px(x, y, 12'h000);
  endtask

  task automatic pulse_update();
    bus.update_panel = 1'b1;
    step();
    bus.update_panel = 1'b0;
  endtask

  function automatic int slot_len(input int p);
    return 4 * W + BK + CD + (BT << p);
  endfunction

  // Observe one slot starting at its first cycle.
  task automatic capture_slot(input int len);
    cap_r1 = '0; cap_r2 = '0; cap_rises = 0; cap_oe = 0; cap_loff = -1; cap_llen = 0;
    cap_abc = '0;
    for (int i = 0; i < len; i++) begin
      if (led_clk === 1'b1 && prev_clk === 1'b0) begin
        if (cap_rises < W) begin
          cap_r1[3*cap_rises +: 3] = led_rgb1;
          cap_r2[3*cap_rises +: 3] = led_rgb2;
        end
        cap_rises++;
      end
      if (led_oe === 1'b0) cap_oe++;
      if (led_latch === 1'b1) begin
        if (cap_llen == 0) cap_loff = i;
        cap_llen++;
      end
      cap_abc = led_abc;
      step();
    end
  endtask

  // Capture rows 0..3 (all planes) of a displayed frame, starting at its first cycle.
  task automatic capture_rows(input string tag, input logic [23:0] row3_r1,
                              input logic [23:0] row1_r2_odd);
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < CB; p++) begin
        capture_slot(slot_len(p));
        chk($sformatf("%s_r%0dp%0d_rises", tag, r, p), cap_rises, W);
        chk($sformatf("%s_r%0dp%0d_abc", tag, r, p), cap_abc, r);
        chk($sformatf("%s_r%0dp%0d_latch_at", tag, r, p), cap_loff, 34);
        chk($sformatf("%s_r%0dp%0d_latch_len", tag, r, p), cap_llen, CD);
        chk($sformatf("%s_r%0dp%0d_oe_low", tag, r, p), cap_oe, BT << p);
        if (r == 3) begin
          chk($sformatf("%s_r3p%0d_rgb1", tag, p), cap_r1, row3_r1);
          chk($sformatf("%s_r3p%0d_rgb2", tag, p), cap_r2, 24'h0);
        end
        if (r == 1) begin
          chk($sformatf("%s_r1p%0d_rgb1", tag, p), cap_r1, 24'h0);
          chk($sformatf("%s_r1p%0d_rgb2", tag, p), cap_r2, (p % 2 == 1) ? row1_r2_odd : 24'h0);
        end
      end
    end
  endtask

  int r0, l0, o0, s0, n;

  initial begin
    bus.new_data = 1'b0; bus.x_address = '0; bus.y_address = '0;
    bus.color = '0; bus.update_panel = 1'b0;
    sysreset = 1'b0;
    steps(4);

    // Reset values
    chk("rst_oe", led_oe, 1);
    chk("rst_clk", led_clk, 0);
    chk("rst_latch", led_latch, 0);
    chk("rst_rgb1", led_rgb1, 0);
    chk("rst_rgb2", led_rgb2, 0);
    chk("rst_abc", led_abc, 0);
    chk("rst_swap_done", bus.swap_done, 0);

    // Dark until valid: three frames with no swap, while filling back buffer 1.
    sysreset = 1'b1;
    r0 = rise_cnt; l0 = latch_cnt; o0 = oe_low_cnt; s0 = swap_cnt;
    clear_back();
    write_px(5, 3, 12'hF00);
    write_px(0, 9, 12'hA00);
    steps(3 * FRAME - 130);
    chk("dark_oe_low", oe_low_cnt - o0, 0);
    chk("dark_clk_rises", rise_cnt - r0, 3 * SCAN * CB * W);
    chk("dark_latches", latch_cnt - l0, 3 * SCAN * CB);
    chk("dark_no_swap", swap_cnt - s0, 0);

    // Single pixel / BCM weighting: request at frame start, swap one frame later.
    pulse_update();
    n = 1;
    while (bus.swap_done !== 1'b1 && n < 5000) begin step(); n++; end
    chk("swap_latency", n, FRAME);
    capture_rows("pix", 24'h020000, 24'h000004);

    // Tear-free swap: fill buffer 0, three requests mid-frame (frame pos 1185..1207).
    s0 = swap_cnt;
    clear_back();
    write_px(2, 3, 12'h0F0);
    for (int k = 0; k < 3; k++) begin pulse_update(); steps(10); end
    n = 0;
    while (bus.swap_done !== 1'b1 && n < 5000) begin step(); n++; end
    chk("tear_swap_at_boundary", n, FRAME - 1218);
    write_px(5, 3, 12'h00F);          // lands in buffer 1, now the back buffer
    steps(FRAME - 1);
    capture_rows("tear", 24'h000080, 24'h000000);
    chk("tear_one_swap", swap_cnt - s0, 1);

    // Boundary write and swap in the last DISPLAY cycle (frame pos 2111).
    steps(FRAME - 1 - 1056);
    bus.update_panel = 1'b1;
    bus.new_data  = 1'b1; bus.x_address = 3'd7; bus.y_address = 4'd3; bus.color = 12'hFFF;
    step();
    bus.update_panel = 1'b0;
    bus.new_data = 1'b0;
    chk("bnd_swap_done", bus.swap_done, 1);
    capture_rows("bnd", 24'hE08000, 24'h000004);

    // Mid-frame reset during row 4 plane 0 DISPLAY (slot offset 38).
    steps(38);
    chk("pre_rst_oe_low", led_oe, 0);
    #2 sysreset = 1'b0;
    #1;
    chk("arst_oe", led_oe, 1);
    chk("arst_clk", led_clk, 0);
    chk("arst_latch", led_latch, 0);
    chk("arst_rgb1", led_rgb1, 0);
    chk("arst_rgb2", led_rgb2, 0);
    chk("arst_abc", led_abc, 0);
    chk("arst_swap_done", bus.swap_done, 0);
    @(negedge clk);
    steps(2);
    sysreset = 1'b1;
    capture_slot(slot_len(0));
    chk("restart_s0_rises", cap_rises, W);
    chk("restart_s0_abc", cap_abc, 0);
    chk("restart_s0_latch_at", cap_loff, 34);
    chk("restart_s0_dark", cap_oe, 0);
    capture_slot(slot_len(1));
    chk("restart_s1_latch_at", cap_loff, 34);
    chk("restart_s1_abc", cap_abc, 0);
    chk("restart_s1_dark", cap_oe, 0);

    chk("latch_oe_abc_rules", viol_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
